// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store unit bridging a simple CPU request port to an AXI-lite-style master.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned requests without touching the bus.
module lsu_axi_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake rule on every channel: a transfer happens at a rising edge where valid && ready;
    // a source keeps valid and its payload stable until that edge.
    input  logic              req_valid,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic              rready,
    input  logic [31:0]       rdata,
    input  logic              rresp,
    input  logic              rvalid,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [31:0]       wstrb,
    output logic              wvalid,
    input  logic              wready,
    output logic              bready,
    input  logic              bresp,
    input  logic              bvalid,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic        misaligned;
    logic [3:0]  size_mask;
    logic [3:0]  strb_sh;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_sh;
    logic        aw_fin;
    logic        w_fin;

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        size_mask = 4'b1111;
        case (req_size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Lanes pushed past byte 3 are simply lost; misaligned accesses see partial data.
    assign strb_sh  = size_mask << req_addr[1:0];
    assign wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
    assign rdata_sh = rdata >> {off_q, 3'b000};

    assign aw_fin = !awvalid || awready;
    assign w_fin  = !wvalid || wready;

    function automatic logic [31:0] extend(input logic [31:0] s, input logic [1:0] sz,
                                           input logic sx);
        logic [31:0] r;
        case (sz)
            2'd0:    r = sx ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
            2'd1:    r = sx ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            araddr     <= '0;
            awaddr     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q  <= req_addr[1:0];
                        size_q <= req_size;
                        sext_q <= req_sext;
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= DONE;
                        end else if (req_wen) begin
                            awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            wdata   <= wdata_sh;
                            wstrb   <= {28'b0, strb_sh};
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_rdata <= extend(rdata_sh, size_q, sext_q);
                        resp_err   <= rresp;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WRITE: begin
                    // AW and W complete independently, in either order or together.
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready <= 1'b1;
                        state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= bresp;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: drives requests and a scripted responder from the falling edge.
// Build with LSU_MISALIGN_CHECK_EN defined to exercise the misalignment rejection path.
module tb_lsu_axi_master;

    logic        clk;
    logic        rst;
    logic        req_valid, req_wen, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata, wstrb, rdata;
    logic        arvalid, arready, rready, rresp, rvalid;
    logic        awvalid, awready, wvalid, wready, bready, bresp, bvalid;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    lsu_axi_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bresp(bresp), .bvalid(bvalid),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Zero-wait load: accept at T, AR at T+1, R at T+2, resp_valid in the following cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sext, input logic [31:0] rd, input logic rr,
                           input logic [31:0] exp_araddr, input logic [31:0] exp_data);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_size = size; req_sext = sext;
        arready = 1'b1;
        check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".arvalid"}, {31'b0, arvalid}, 32'd1);
        check({tag, ".araddr"}, araddr, exp_araddr);
        @(negedge clk);
        check({tag, ".rready"}, {31'b0, rready}, 32'd1);
        check({tag, ".arvalid_low"}, {31'b0, arvalid}, 32'd0);
        rvalid = 1'b1; rdata = rd; rresp = rr;
        @(negedge clk);
        rvalid = 1'b0; rdata = '0; rresp = 1'b0;
        check({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata, exp_data);
        check({tag, ".resp_err"}, {31'b0, resp_err}, {31'b0, rr});
        @(negedge clk);
        check({tag, ".resp_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    // Zero-wait store: AW and W handshake together at T+1, B at T+2.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wd, input logic br, input logic [31:0] exp_awaddr,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_wstrb);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_size = size; req_wdata = wd;
        req_sext = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".awvalid"}, {31'b0, awvalid}, 32'd1);
        check({tag, ".wvalid"}, {31'b0, wvalid}, 32'd1);
        check({tag, ".awaddr"}, awaddr, exp_awaddr);
        check({tag, ".wdata"}, wdata, exp_wdata);
        check({tag, ".wstrb"}, wstrb, exp_wstrb);
        @(negedge clk);
        check({tag, ".bready"}, {31'b0, bready}, 32'd1);
        check({tag, ".aw_w_low"}, {30'b0, awvalid, wvalid}, 32'd0);
        bvalid = 1'b1; bresp = br;
        @(negedge clk);
        bvalid = 1'b0; bresp = 1'b0;
        check({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, ".resp_err"}, {31'b0, resp_err}, {31'b0, br});
        check({tag, ".resp_rdata"}, resp_rdata, 32'd0);
        @(negedge clk);
        check({tag, ".resp_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_sext = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.valids", {25'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err},
              32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.wstrb", wstrb, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", {31'b0, req_ready}, 32'd1);

        do_load("ld_word", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0,
                32'h8000_0004, 32'hDEAD_BEEF);
        do_load("ld_byte_sx", 32'h8000_0003, 2'd0, 1'b1, 32'h85FF_FFFF, 1'b0,
                32'h8000_0000, 32'hFFFF_FF85);
        do_load("ld_byte_zx", 32'h8000_0003, 2'd0, 1'b0, 32'h85FF_FFFF, 1'b0,
                32'h8000_0000, 32'h0000_0085);
        do_load("ld_half_sx", 32'h8000_0002, 2'd1, 1'b1, 32'h8001_1234, 1'b1,
                32'h8000_0000, 32'hFFFF_8001);
        do_load("ld_half_zx", 32'h8000_0000, 2'd1, 1'b0, 32'h8001_9234, 1'b0,
                32'h8000_0000, 32'h0000_9234);

        do_store("st_half", 32'h8000_0002, 2'd1, 32'h0000_1234, 1'b0,
                 32'h8000_0000, 32'h1234_0000, 32'h0000_000C);
        do_store("st_byte", 32'h8000_0101, 2'd0, 32'h0000_00AB, 1'b1,
                 32'h8000_0100, 32'h0000_AB00, 32'h0000_0002);
        do_store("st_word", 32'h8000_0020, 2'd3, 32'hCAFE_F00D, 1'b0,
                 32'h8000_0020, 32'hCAFE_F00D, 32'h0000_000F);

        // W completes first, AW is held three more cycles before awready arrives.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_size = 2'd2;
        req_wdata = 32'hA5A5_A5A5; awready = 1'b0; wready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("st_dly.both_valid", {30'b0, awvalid, wvalid}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_dly.aw_held_w_low", {29'b0, awvalid, wvalid, bready}, 32'd4);
            check("st_dly.awaddr_stable", awaddr, 32'h8000_0010);
        end
        awready = 1'b1;
        @(negedge clk);
        check("st_dly.bready", {29'b0, awvalid, wvalid, bready}, 32'd1);
        bvalid = 1'b1; bresp = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; bresp = 1'b0;
        check("st_dly.resp", {29'b0, resp_valid, resp_err, bready}, 32'd6);
        @(negedge clk);
        check("st_dly.single_resp", {31'b0, resp_valid}, 32'd0);
        check("st_dly.idle", {31'b0, req_ready}, 32'd1);

`ifdef LSU_MISALIGN_CHECK_EN
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0001; req_size = 2'd2;
        req_sext = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("mis.no_arvalid", {31'b0, arvalid}, 32'd0);
        check("mis.resp", {30'b0, resp_valid, resp_err}, 32'd3);
        check("mis.rdata", resp_rdata, 32'd0);
        @(negedge clk);
        check("mis.idle", {30'b0, req_ready, resp_valid}, 32'd2);
`else
        do_load("mis_ld", 32'h8000_0001, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0,
                32'h8000_0000, 32'h00DE_ADBE);
        do_store("mis_st", 32'h8000_0003, 2'd2, 32'h1122_3344, 1'b0,
                 32'h8000_0000, 32'h4400_0000, 32'h0000_0008);
`endif

        // Reset while waiting for read data abandons the load silently.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0040; req_size = 2'd2;
        arready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid.in_rdata", {31'b0, rready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.quiet", {26'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid},
              32'd0);
        check("rst_mid.req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check("rst_mid.no_resp", {31'b0, resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 Parameter: ADDR_W, default 32, address width; all bus addresses SHALL be ADDR_W bits.
REQ-002 Ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-003 CPU side, inputs: req_valid 1 (request present); req_wen 1 (1=store, 0=load); req_addr ADDR_W (byte address); req_wdata 32 (store data, LSB-aligned); req_size 2 (0=byte, 1=half, 2/3=word); req_sext 1 (sign-extend load).
REQ-004 CPU side, outputs: req_ready 1 (request accepted this cycle); resp_valid 1 (one-cycle completion pulse); resp_rdata 32 (extended load data); resp_err 1 (error).
REQ-005 Read address channel: araddr output ADDR_W; arvalid output 1; arready input 1.
REQ-006 Read data channel: rready output 1; rdata input 32; rresp input 1 (1=error); rvalid input 1.
REQ-007 Write address channel: awaddr output ADDR_W; awvalid output 1; awready input 1.
REQ-008 Write data channel: wdata output 32; wstrb output 32 (bits 31:4 always 0); wvalid output 1; wready input 1.
REQ-009 Write response channel: bready output 1; bresp input 1 (1=error); bvalid input 1.

Function
REQ-010 States SHALL be IDLE, RADDR, RDATA, WRITE, WRESP, DONE; one outstanding transaction maximum.
REQ-011 req_ready SHALL equal (state==IDLE), combinationally; a request is accepted at a clock edge where req_valid && req_ready.
REQ-012 On accept, addr/wdata/size/sext/wen SHALL be registered; next state is RADDR (load) or WRITE (store), and arvalid or awvalid+wvalid go high at that same edge.
REQ-013 araddr/awaddr SHALL be {addr[ADDR_W-1:2],2'b00}; byte offset off=addr[1:0].
REQ-014 RADDR: arvalid=1 until an edge with arvalid&&arready; then arvalid<=0, rready<=1, state RDATA.
REQ-015 RDATA: on edge with rvalid&&rready, rready<=0, capture rdata>>(8*off) and rresp, state DONE.
REQ-016 WRITE: awvalid and wvalid held independently; each SHALL drop at the edge of its own handshake; both handshakes may complete in the same edge or in either order; when both are done, bready<=1, state WRESP.
REQ-017 wdata SHALL be req_wdata<<(8*off); wstrb[3:0] SHALL be (size mask 4'b0001/4'b0011/4'b1111)<<off, truncated to 4 bits.
REQ-018 WRESP: on edge with bvalid&&bready, bready<=0, capture bresp, state DONE.
REQ-019 DONE: resp_valid=1 for exactly one cycle, resp_err=captured resp, then IDLE; req_ready is 0 in DONE.
REQ-020 resp_rdata for loads: byte/half extracted from shifted data, sign-extended if req_sext else zero-extended; word passed through; SHALL be 0 for stores.
REQ-021 Minimum latency with zero-wait responder: accept edge T, address handshake T+1, data/resp handshake T+2, resp_valid high in cycle after T+2 edge.
REQ-022 Outputs araddr/awaddr/wdata/wstrb SHALL remain stable while the corresponding valid is high.

Reset
REQ-023 On rst, all of arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err SHALL be 0, resp_rdata 0, wstrb 0, state IDLE.
REQ-024 rst asserted mid-transaction SHALL abandon it with no resp_valid; the system resets the responder together.

Configuration
REQ-025 Macro LSU_MISALIGN_CHECK_EN defined: a request with (size==1 && addr[0]) or (size>=2 && addr[1:0]!=0) SHALL issue no bus transaction, go directly from IDLE to DONE, and give resp_err=1, resp_rdata=0.
REQ-026 Macro undefined: misaligned requests SHALL proceed on the bus per REQ-013..REQ-020 (strobes truncated, missing read bytes zero before extension); no error is generated by the block.

Verification
REQ-027 Load word addr 0x80000004, responder returns rdata 0xDEADBEEF rresp 0 -> araddr 0x80000004, resp_rdata 0xDEADBEEF, resp_err 0, resp_valid one cycle.
REQ-028 Load byte sext addr 0x80000003, rdata 0x85FFFFFF -> resp_rdata 0xFFFFFF85; same with req_sext=0 -> 0x00000085.
REQ-029 Store half 0x1234 addr 0x80000002 -> awaddr 0x80000000, wdata 0x12340000, wstrb 0x0000000C, resp_valid after bvalid with bresp 0.
REQ-030 Store with awready delayed 3 cycles after wready handshake -> wvalid drops after 1 handshake, awvalid held 3 cycles, exactly one bready handshake, one resp_valid.
REQ-031 Load word addr 0x80000001: with LSU_MISALIGN_CHECK_EN -> no arvalid, resp_err 1 in cycle after accept; without -> arvalid with araddr 0x80000000.
REQ-032 rst asserted while in RDATA -> next cycle all valids/readies 0, req_ready 1, no resp_valid.
